// File: rtl/rx_frame_assembler.sv
// UART-to-ALU frame assembler: collects operand bytes plus an
// opcode and presents the whole frame on a valid/ready handshake.
module rx_frame_assembler #(
  parameter int NB_BYTE        = 8,
  parameter int NB_DATA        = 16,
  parameter int N_OPERANDS     = 2,
  parameter int NB_OPERADOR    = 6,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic [NB_BYTE-1:0]             i_data,
  input  logic                           i_rx_done,
  input  logic                           i_ready,
  output logic [N_OPERANDS*NB_DATA-1:0]  o_operands,
  output logic [NB_OPERADOR-1:0]         o_op,
  output logic                           o_valid,
  output logic                           o_busy,
  output logic                           o_timeout,
  output logic                           o_overrun
);

  localparam int BPO      = NB_DATA / NB_BYTE;
  localparam int NBYTES   = N_OPERANDS * BPO;
  localparam int IW       = $clog2(NBYTES + 1);
  localparam int CW       = (TIMEOUT_CYCLES > 1) ?
                            $clog2(TIMEOUT_CYCLES) : 1;
  localparam int NB_STAGE = N_OPERANDS * NB_DATA;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    VALID
  } state_t;

  state_t                 state, state_n;
  logic                   rx_prev;
  logic                   accept;
  logic [IW-1:0]          idx, idx_n;
  logic [CW-1:0]          idle_cnt, idle_cnt_n;
  logic [NB_STAGE-1:0]    stage, stage_n;
  logic [NB_STAGE-1:0]    opnds_n;
  logic [NB_OPERADOR-1:0] op_n;
  logic                   timeout_n;
  logic                   overrun_n;

  // A level already high when reset releases is not a new byte.
  assign accept  = i_rx_done & ~rx_prev;
  assign o_valid = (state == VALID);
  assign o_busy  = (state == COLLECT);

  // State, staging, counters and registered outputs.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state      <= IDLE;
      rx_prev    <= 1'b1;
      idx        <= '0;
      idle_cnt   <= '0;
      stage      <= '0;
      o_operands <= '0;
      o_op       <= '0;
      o_timeout  <= 1'b0;
      o_overrun  <= 1'b0;
    end else begin
      state      <= state_n;
      rx_prev    <= i_rx_done;
      idx        <= idx_n;
      idle_cnt   <= idle_cnt_n;
      stage      <= stage_n;
      o_operands <= opnds_n;
      o_op       <= op_n;
      o_timeout  <= timeout_n;
      o_overrun  <= overrun_n;
    end
  end

  // Next-state: byte collection, frame completion, timeout, handshake.
  always_comb begin
    state_n    = state;
    idx_n      = idx;
    idle_cnt_n = '0;
    stage_n    = stage;
    opnds_n    = o_operands;
    op_n       = o_op;
    timeout_n  = 1'b0;
    overrun_n  = 1'b0;
    unique case (state)
      IDLE, COLLECT: begin
        if (accept) begin
          if (idx == IW'(NBYTES)) begin
            opnds_n = stage;
            op_n    = i_data[NB_OPERADOR-1:0];
            idx_n   = '0;
            state_n = VALID;
          end else begin
            for (int i = 0; i < NBYTES; i++) begin
              if (idx == IW'(i)) begin
                stage_n[i*NB_BYTE +: NB_BYTE] = i_data;
              end
            end
            idx_n   = idx + 1'b1;
            state_n = COLLECT;
          end
        end else if (state == COLLECT) begin
          if (TIMEOUT_CYCLES != 0 &&
              idle_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            idx_n     = '0;
            timeout_n = 1'b1;
            state_n   = IDLE;
          end else begin
            idle_cnt_n = idle_cnt + 1'b1;
          end
        end
      end
      VALID: begin
        overrun_n = accept;
        if (i_ready) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_rx_frame_assembler.sv
// Directed bench for rx_frame_assembler: default, short-timeout
// and three-byte-operand instances share one stimulus stream.
module tb_rx_frame_assembler;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data;
  logic       rx_done;
  logic       ready;

  logic [31:0] opa, opt;
  logic [23:0] opc;
  logic [5:0]  op_a, op_t, op_c;
  logic        va, ba, ta, ova;
  logic        vt, bt, tt, ovt;
  logic        vc, bc, tc, ovc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rx_frame_assembler dut_a (
    .i_clk(clk), .i_rst(rst), .i_data(data),
    .i_rx_done(rx_done), .i_ready(ready),
    .o_operands(opa), .o_op(op_a), .o_valid(va),
    .o_busy(ba), .o_timeout(ta), .o_overrun(ova)
  );

  rx_frame_assembler #(.TIMEOUT_CYCLES(20)) dut_t (
    .i_clk(clk), .i_rst(rst), .i_data(data),
    .i_rx_done(rx_done), .i_ready(ready),
    .o_operands(opt), .o_op(op_t), .o_valid(vt),
    .o_busy(bt), .o_timeout(tt), .o_overrun(ovt)
  );

  rx_frame_assembler #(.N_OPERANDS(3), .NB_DATA(8)) dut_c (
    .i_clk(clk), .i_rst(rst), .i_data(data),
    .i_rx_done(rx_done), .i_ready(ready),
    .o_operands(opc), .o_op(op_c), .o_valid(vc),
    .o_busy(bc), .o_timeout(tc), .o_overrun(ovc)
  );

  typedef struct packed {
    logic [39:0] b;
    logic [31:0] eo;
    logic [5:0]  eop;
  } vec_t;

  vec_t        vecs [4];
  logic [31:0] prev;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_bytes(input logic [39:0] b, input int first,
                            input int n, input int hold);
    for (int i = first; i < first + n; i++) begin
      @(negedge clk);
      data    = b[i*8 +: 8];
      rx_done = 1'b1;
      repeat (hold) @(negedge clk);
      rx_done = 1'b0;
    end
  endtask

  task automatic run_frame(input vec_t v, input string name);
    send_bytes(v.b, 0, 4, 1);
    chk({name, " partial valid"}, 64'(va), 64'd0);
    chk({name, " partial busy"}, 64'(ba), 64'd1);
    chk({name, " partial data"}, 64'(opa), 64'(prev));
    send_bytes(v.b, 4, 1, 1);
    chk({name, " valid"}, 64'(va), 64'd1);
    chk({name, " operands"}, 64'(opa), 64'(v.eo));
    chk({name, " op"}, 64'(op_a), 64'(v.eop));
    chk({name, " busy"}, 64'(ba), 64'd0);
    if (ready) begin
      @(negedge clk);
      chk({name, " valid drop"}, 64'(va), 64'd0);
    end
    prev = v.eo;
  endtask

  initial begin
    int pulses;
    int at;
    vecs[0] = '{40'h05_ABCD_1234, 32'hABCD_1234, 6'h05};
    vecs[1] = '{40'h3F_0000_FFFF, 32'h0000_FFFF, 6'h3F};
    vecs[2] = '{40'hC7_0403_0201, 32'h0403_0201, 6'h07};
    vecs[3] = '{40'h2A_7FFF_8000, 32'h7FFF_8000, 6'h2A};
    prev    = '0;
    rst     = 1'b0;
    data    = '0;
    rx_done = 1'b0;
    ready   = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst operands", 64'(opa), 64'd0);
    chk("rst op", 64'(op_a), 64'd0);
    chk("rst valid", 64'(va), 64'd0);
    chk("rst busy", 64'(ba), 64'd0);
    chk("rst timeout", 64'(ta), 64'd0);
    chk("rst overrun", 64'(ova), 64'd0);
    rst = 1'b1;

    for (int k = 0; k < 4; k++) begin
      run_frame(vecs[k], $sformatf("vec%0d", k));
    end

    ready = 1'b0;
    send_bytes(vecs[0].b, 0, 5, 1);
    chk("stall valid", 64'(va), 64'd1);
    repeat (3) begin
      @(negedge clk);
      chk("stall hold valid", 64'(va), 64'd1);
      chk("stall hold data", 64'(opa), 64'(vecs[0].eo));
    end
    send_bytes(40'h77, 0, 1, 1);
    chk("overrun pulse", 64'(ova), 64'd1);
    repeat (5) begin
      @(negedge clk);
      chk("overrun low", 64'(ova), 64'd0);
      chk("stall hold valid", 64'(va), 64'd1);
      chk("stall hold data", 64'(opa), 64'(vecs[0].eo));
      chk("stall hold op", 64'(op_a), 64'(vecs[0].eop));
    end
    ready = 1'b1;
    @(negedge clk);
    chk("release valid", 64'(va), 64'd0);
    prev = vecs[0].eo;
    run_frame(vecs[1], "after overrun");

    send_bytes(40'h22_11, 0, 2, 1);
    pulses = 0;
    at     = 0;
    for (int i = 1; i <= 25; i++) begin
      @(negedge clk);
      if (i == 19) chk("to busy before", 64'(bt), 64'd1);
      if (tt) begin
        pulses++;
        if (at == 0) at = i;
      end
    end
    chk("to pulse count", 64'(pulses), 64'd1);
    chk("to pulse cycle", 64'(at), 64'd20);
    chk("to busy after", 64'(bt), 64'd0);
    chk("to keep data", 64'(opt), 64'h0000_FFFF);
    chk("to keep op", 64'(op_t), 64'h3F);
    send_bytes(vecs[3].b, 0, 5, 1);
    chk("to next valid", 64'(vt), 64'd1);
    chk("to next data", 64'(opt), 64'(vecs[3].eo));
    chk("to next op", 64'(op_t), 64'(vecs[3].eop));

    @(negedge clk);
    rst     = 1'b0;
    rx_done = 1'b1;
    data    = 8'h34;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (50) @(negedge clk);
    chk("high at release", 64'(ba), 64'd0);
    rx_done = 1'b0;
    ready   = 1'b0;
    send_bytes(vecs[2].b, 0, 5, 50);
    chk("hold valid", 64'(va), 64'd1);
    chk("hold data", 64'(opa), 64'(vecs[2].eo));
    chk("hold op", 64'(op_a), 64'(vecs[2].eop));
    ready = 1'b1;
    @(negedge clk);
    chk("hold drop", 64'(va), 64'd0);

    send_bytes(vecs[3].b, 0, 3, 1);
    chk("mid busy", 64'(ba), 64'd1);
    rst = 1'b0;
    @(negedge clk);
    chk("mid rst operands", 64'(opa), 64'd0);
    chk("mid rst op", 64'(op_a), 64'd0);
    chk("mid rst valid", 64'(va), 64'd0);
    chk("mid rst busy", 64'(ba), 64'd0);
    chk("mid rst timeout", 64'(ta), 64'd0);
    chk("mid rst overrun", 64'(ova), 64'd0);
    rst  = 1'b1;
    prev = '0;
    run_frame(vecs[3], "after rst");

    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    send_bytes(40'hFF_33_22_11, 0, 3, 1);
    chk("c3 partial valid", 64'(vc), 64'd0);
    chk("c3 partial busy", 64'(bc), 64'd1);
    send_bytes(40'hFF_33_22_11, 3, 1, 1);
    chk("c3 valid", 64'(vc), 64'd1);
    chk("c3 operands", 64'(opc), 64'h33_22_11);
    chk("c3 op", 64'(op_c), 64'h3F);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/rx_frame_assembler.md
# rx_frame_assembler

Parametrised UART-to-ALU frame assembler. It sits between the UART receiver and the ALU. It assembles a fixed-length frame of bytes into N_OPERANDS operands, each NB_DATA bits wide and built from several bytes, plus one opcode. It presents the complete frame on a valid/ready handshake and discards stalled partial frames after an inter-byte timeout.

## Interface
- NB_BYTE, 8, width of one UART word
- NB_DATA, 16, operand width; integer multiple of NB_BYTE (BPO = NB_DATA/NB_BYTE bytes per operand)
- N_OPERANDS, 2, operands per frame (≥1)
- NB_OPERADOR, 6, opcode width (≤ NB_BYTE)
- TIMEOUT_CYCLES, 1000, max idle clocks between bytes inside a frame; 0 disables the timeout
- i_clk  in  1  clock, all logic on rising edge
- i_rst  in  1  reset, synchronous, active-low
- i_data  in  NB_BYTE  received byte, stable while i_rx_done high
- i_rx_done  in  1  UART byte-done flag; a byte is taken only on its rising edge
- i_ready  in  1  ALU accepts frame
- o_operands  out  N_OPERANDS*NB_DATA  flattened operands; operand k at bits [k*NB_DATA +: NB_DATA]
- o_op  out  NB_OPERADOR  opcode
- o_valid  out  1  frame available on o_operands/o_op
- o_busy  out  1  partial frame in progress (state COLLECT)
- o_timeout  out  1  one-cycle pulse: partial frame discarded
- o_overrun  out  1  one-cycle pulse: byte dropped while o_valid high

## Operation
- Edge detect: rx_prev is registered from i_rx_done. rx_prev resets to 1, so a level that is already high at reset release is not a byte. accept = i_rx_done & ~rx_prev.
- Frame order: operand 0 byte 0 … operand 0 byte BPO-1, operand 1 …, then the opcode byte. Total N_OPERANDS*BPO+1 bytes.
- Bytes within an operand are little-endian: byte j goes to bits [j*NB_BYTE +: NB_BYTE].
- Opcode = i_data[NB_OPERADOR-1:0]; upper bits are ignored.
- Bytes are written into an internal staging register. o_operands and o_op change only when a frame completes, so outputs never show a partial frame.
- States:
  - IDLE: on accept, store byte 0 of operand 0, byte_idx=1, go to COLLECT. If the frame length is 1 byte (opcode only), load the outputs and go to VALID instead.
  - COLLECT: each accept stores the byte at byte_idx and increments byte_idx. The accept at byte_idx = N_OPERANDS*BPO is the opcode: copy staging to o_operands, load o_op, go to VALID.
  - VALID: o_valid=1. If i_ready=1, go to IDLE on the next edge. Any accept in VALID is dropped and pulses o_overrun for one cycle; staging is unchanged.
- Timeout (COLLECT only): idle counter clears on every accept and increments otherwise. When it reaches TIMEOUT_CYCLES-1 with no accept:
  - clear byte_idx, pulse o_timeout, go to IDLE;
  - o_operands/o_op keep their last completed frame.
  - An accept in the same cycle as expiry wins: byte stored, no timeout.
- byte_idx width = clog2(N_OPERANDS*BPO+1). It never wraps; it returns to 0 only on frame completion, timeout, or reset.
- Reset (any cycle, including mid-frame or in VALID):
  - state IDLE, staging and byte_idx cleared;
  - o_operands=0, o_op=0, o_valid=0, o_busy=0, o_timeout=0, o_overrun=0;
  - rx_prev=1, idle counter 0.

## Timing
- A byte is sampled at the rising edge where accept=1, i.e. the first edge seeing i_rx_done high after a low.
- Opcode accept at edge k: o_operands, o_op and o_valid are updated at edge k and visible in cycle k+1.
- Handshake: transfer occurs at the edge where o_valid=1 and i_ready=1. o_valid drops after that edge.
  - With i_ready tied high, o_valid is high for exactly one cycle.
- A new frame's first byte can be accepted in the cycle after the transfer, since the state is IDLE by then.
- o_valid and o_busy are registered (state-decoded). o_timeout and o_overrun are registered one-cycle pulses.
- Holding i_rx_done high for many cycles yields exactly one byte.

## Test plan
- Defaults, i_ready=1; send 0x34,0x12,0xCD,0xAB,0x05 -> one cycle after the 5th accept: o_operands[15:0]=0x1234, [31:16]=0xABCD, o_op=0x05, o_valid high one cycle.
- i_ready=0 for 10 cycles after a frame -> o_valid and data stable for all 10 cycles. Extra byte 0x77 sent meanwhile -> o_overrun pulses once, next frame unaffected. Raise i_ready -> o_valid low the next cycle.
- TIMEOUT_CYCLES=20; send 0x11,0x22 then stop -> o_timeout pulses 20 cycles after the last accept, o_busy low, outputs still hold the previous frame. A following full 5-byte frame completes correctly.
- i_rx_done held high 50 cycles per byte, and high at reset release -> only one byte counted per rising edge; no byte counted at reset release.
- Assert i_rst after 3 bytes of a frame -> next cycle all outputs 0, state IDLE. A fresh 5-byte frame then decodes correctly.
- N_OPERANDS=3, NB_DATA=8, opcode byte 0xFF -> 4-byte frame, o_op=6'h3F (upper bits dropped), operands in order.
